// File: rtl/arm_cond_pkg.sv
// ARM condition codes and NZCV flag layout.
// Shared by the condition-execute and branch units.
package arm_cond_pkg;

  typedef logic [3:0] nzcv_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator.
// Maps a 4-bit condition field and NZCV flags to pass/fail.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  nzcv_t      nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Decode the condition against the flags
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Condition-execute stage between decode and execute.
// Tracks in-flight flag writers and forwards same-cycle writeback.
module cond_exec_unit
  import arm_cond_pkg::*;
#(
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_cond,
  input  logic       in_sets_flags,
  input  logic       flags_n,
  input  logic       flags_z,
  input  logic       flags_c,
  input  logic       flags_v,
  input  logic       flag_wr,
  input  logic [3:0] flag_wr_nzcv,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_execute,
  output logic [3:0] out_cond,
  output logic       err_underflow
);

  localparam logic [PEND_W-1:0] P_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] P_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] P_ZERO = '0;

  logic [PEND_W-1:0] pending;
  logic              last_writer;
  nzcv_t             eff;
  logic              pass;
  logic              hazard;
  logic              full_block;
  logic              accept;
  logic              inc;
  logic              dec;

  assign last_writer = flag_wr && (pending == P_ONE);
  assign eff = last_writer ? flag_wr_nzcv
             : {flags_n, flags_z, flags_c, flags_v};

  cond_check u_chk (
    .cond (in_cond),
    .nzcv (eff),
    .pass (pass)
  );

  // Stall and accept decisions
  always_comb begin
    hazard = (in_cond != COND_AL) && (in_cond != COND_NV)
           && (pending != P_ZERO) && !last_writer;
    full_block = in_sets_flags && (pending == P_MAX) && !flag_wr;
    in_ready = (!out_valid || out_ready) && !hazard && !full_block;
    accept = in_valid && in_ready;
    inc = accept && in_sets_flags && pass;
    dec = flag_wr && (pending != P_ZERO);
  end

  // Registered output stage with hold on backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_execute <= 1'b0;
      out_cond    <= 4'b0000;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_execute <= pass;
      out_cond    <= in_cond;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Pending flag-writer count and sticky underflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= P_ZERO;
      err_underflow <= 1'b0;
    end else begin
      if (inc && !dec && (pending != P_MAX))
        pending <= pending + P_ONE;
      else if (dec && !inc)
        pending <= pending - P_ONE;
      if (flag_wr && (pending == P_ZERO))
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit.
// Directed steps then random traffic against a reference model.
module tb_cond_exec_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cond;
  logic       in_sets_flags;
  logic       flags_n, flags_z, flags_c, flags_v;
  logic       flag_wr;
  logic [3:0] flag_wr_nzcv;
  logic       out_valid;
  logic       out_ready;
  logic       out_execute;
  logic [3:0] out_cond;
  logic       err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  int       m_pend;
  logic     m_err;
  logic     m_ov;
  logic     m_ex;
  logic [3:0] m_cond;

  always #5 clk = ~clk;

  cond_exec_unit dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_cond       (in_cond),
    .in_sets_flags (in_sets_flags),
    .flags_n       (flags_n),
    .flags_z       (flags_z),
    .flags_c       (flags_c),
    .flags_v       (flags_v),
    .flag_wr       (flag_wr),
    .flag_wr_nzcv  (flag_wr_nzcv),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_execute   (out_execute),
    .out_cond      (out_cond),
    .err_underflow (err_underflow)
  );

  // Pairs of conditions share a predicate; odd codes invert it.
  function automatic logic ref_pass(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_err = 1'b0; m_ov = 1'b0;
    m_ex = 1'b0; m_cond = 4'h0;
  endtask

  task automatic set_in(input logic v, input logic [3:0] c,
                        input logic s, input logic [3:0] f,
                        input logic wr, input logic [3:0] wn,
                        input logic ordy);
    in_valid = v; in_cond = c; in_sets_flags = s;
    {flags_n, flags_z, flags_c, flags_v} = f;
    flag_wr = wr; flag_wr_nzcv = wn; out_ready = ordy;
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    logic hz, fb, rdy, acc, p;
    logic [3:0] eff;
    #1;
    hz = (in_cond < 4'hE) && (m_pend > 0)
       && !(m_pend == 1 && flag_wr);
    fb = in_sets_flags && (m_pend == 3) && !flag_wr;
    rdy = (!m_ov || out_ready) && !hz && !fb;
    check({tag, ".in_ready"}, {3'b0, in_ready}, {3'b0, rdy});
    acc = in_valid && rdy;
    eff = (flag_wr && m_pend == 1) ? flag_wr_nzcv
        : {flags_n, flags_z, flags_c, flags_v};
    p = ref_pass(in_cond, eff);
    if (flag_wr && m_pend == 0) m_err = 1'b1;
    m_pend = m_pend + ((acc && in_sets_flags && p) ? 1 : 0)
           - ((flag_wr && m_pend > 0) ? 1 : 0);
    if (acc) begin
      m_ov = 1'b1; m_ex = p; m_cond = in_cond;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {3'b0, out_valid}, {3'b0, m_ov});
    if (m_ov) begin
      check({tag, ".out_execute"}, {3'b0, out_execute}, {3'b0, m_ex});
      check({tag, ".out_cond"}, out_cond, m_cond);
    end
    check({tag, ".err"}, {3'b0, err_underflow}, {3'b0, m_err});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.out_valid", {3'b0, out_valid}, 4'h0);
    check("rst.out_execute", {3'b0, out_execute}, 4'h0);
    check("rst.out_cond", out_cond, 4'h0);
    check("rst.err", {3'b0, err_underflow}, 4'h0);
    reset = 1'b0;

    // EQ with Z set executes, NE squashes
    set_in(1, 4'h0, 0, 4'b0100, 0, 4'h0, 1);
    cycle("eq");
    check("eq.lit_exec", {3'b0, out_execute}, 4'h1);
    set_in(1, 4'h1, 0, 4'b0100, 0, 4'h0, 1);
    cycle("ne");
    check("ne.lit_exec", {3'b0, out_execute}, 4'h0);

    // AL flag setter, then GT stalls until writeback bypass
    set_in(1, 4'hE, 1, 4'b0100, 0, 4'h0, 1);
    cycle("al_s");
    set_in(1, 4'hC, 0, 4'b0100, 0, 4'h0, 1);
    cycle("gt_stall0");
    check("gt_stall.lit_rdy", {3'b0, in_ready}, 4'h0);
    cycle("gt_stall1");
    set_in(1, 4'hC, 0, 4'b0100, 1, 4'b0000, 1);
    cycle("gt_bypass");
    check("gt_bypass.lit_exec", {3'b0, out_execute}, 4'h1);

    // Fill the scoreboard, then a fourth setter
    set_in(1, 4'hE, 1, 4'h0, 0, 4'h0, 1);
    cycle("fill1");
    cycle("fill2");
    cycle("fill3");
    cycle("full_blk");
    check("full.lit_rdy", {3'b0, in_ready}, 4'h0);
    set_in(1, 4'hE, 1, 4'h0, 1, 4'h5, 1);
    cycle("full_wr");
    set_in(0, 4'hE, 0, 4'h0, 1, 4'h0, 1);
    cycle("drain1");
    cycle("drain2");
    cycle("drain3");

    // Squashed setter does not count
    set_in(1, 4'h0, 1, 4'b0000, 0, 4'h0, 1);
    cycle("sq_s");
    set_in(1, 4'hC, 0, 4'b0100, 0, 4'h0, 1);
    cycle("sq_chk");

    // Backpressure holds the output register
    set_in(1, 4'h4, 0, 4'b1000, 0, 4'h0, 1);
    cycle("bp_acc");
    set_in(1, 4'h2, 0, 4'b0000, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) cycle("bp_hold");
    check("bp.lit_cond", out_cond, 4'h4);
    out_ready = 1'b1;
    cycle("bp_rel");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0));
      cycle("rnd");
    end

    // Drain to zero then underflow
    set_in(0, 4'hE, 0, 4'h0, 1, 4'h0, 1);
    for (int i = 0; i < 4; i++) cycle("uf");
    set_in(0, 4'hE, 0, 4'h0, 0, 4'h0, 1);
    cycle("uf_sticky");
    check("uf.lit_err", {3'b0, err_underflow}, 4'h1);

    // Async reset mid-cycle with a held output
    set_in(1, 4'hE, 0, 4'h0, 0, 4'h0, 0);
    cycle("pre_rst");
    #3 reset = 1'b1;
    #1;
    check("arst.out_valid", {3'b0, out_valid}, 4'h0);
    check("arst.err", {3'b0, err_underflow}, 4'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 4'hE, 0, 4'h0, 1, 4'h0, 1);
    cycle("post_rst_uf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
